reg_file_neg: RTL and testbench
===============================

Name: reg_file_neg

Overview:
- Parametrised general-purpose register file for the 10-bit processor datapath. It replaces the discrete fixed-width registers.
- Provides DEPTH words of WIDTH bits with one write port and two independent read ports. This lets the ALU fetch both operands in one cycle.
- All storage updates on the falling edge of Clkb.
- Adds async reset, synchronous bulk clear, optional hardwired-zero R0 and optional write-to-read bypass.

Parameters:
- WIDTH, 10, data word width in bits (≥1).
- DEPTH, 4, number of registers (≥2, power of two).
- ZERO_REG0, 0, when 1 R0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a read of the address being written this cycle returns WrData.
- Local constant ADDR_W = clog2(DEPTH).

Ports:
- Clkb  input  1  system clock; all state changes on the falling edge.
- Rstb  input  1  asynchronous active-low reset.
- WrEn  input  1  write enable, sampled at the falling edge.
- WrAddr  input  ADDR_W  write address.
- WrData  input  WIDTH  write data.
- ClrAll  input  1  synchronous clear of every register, sampled at the falling edge.
- RdAddrA  input  ADDR_W  read port A address.
- RdAddrB  input  ADDR_W  read port B address.
- RdDataA  output  WIDTH  read port A data.
- RdDataB  output  WIDTH  read port B data.
- WrAck  output  1  registered pulse, high for one cycle after an accepted write.

Behaviour:
- Reset
  - Rstb low clears all registers and WrAck immediately, independent of Clkb.
  - RdDataA and RdDataB then read 0.
  - Deasserting Rstb between edges takes effect at the next falling edge.
- Write
  - On a falling edge with Rstb high, WrEn=1 and ClrAll=0, mem[WrAddr] <= WrData.
  - All other words hold.
  - Write latency is one falling edge.
- Clear
  - On a falling edge with ClrAll=1, all words become 0.
  - ClrAll has priority over WrEn in the same cycle; the write is dropped and WrAck stays 0.
- WrAck
  - Set to 1 at a falling edge where a write is accepted, otherwise 0.
  - A write to R0 with ZERO_REG0=1 is not accepted, so WrAck=0.
- Reads
  - Combinational from storage; the two ports are fully independent.
  - Both ports may address the same word, and each port returns the same value.
- Bypass (BYPASS=1)
  - When WrEn=1, ClrAll=0 and WrAddr equals a port's read address, that port returns WrData in the same cycle.
  - This applies only when the write would be accepted.
- BYPASS=0: a read returns the old value until the falling edge.
- ZERO_REG0=1: R0 reads 0 on both ports, never bypasses, and its storage may be optimised away.
- Address range: with DEPTH a power of two, every address is valid; there is no out-of-range case.
- Back-to-back writes to the same address on consecutive edges: the last write wins, and each accepted write produces its own WrAck pulse.
- Width: no arithmetic. Data passes through unmodified at WIDTH bits, with no sign handling.

Decomposition:
- Shared package proc_pkg holds:
  - WORD_W=10
  - NUM_REGS=4
  - REG_ADDR_W
  - named register index constants R0..R3
- Top-level instantiation passes WIDTH=proc_pkg::WORD_W and DEPTH=proc_pkg::NUM_REGS.
- One natural sub-module, reg_word_neg:
  - a WIDTH-bit falling-edge register with enable, synchronous clear and async active-low reset.
  - It is the parametrised generalisation of the per-bit enabled flip-flop.
  - It is instantiated DEPTH times via generate, with enable = WrEn & (WrAddr==i).
- Read muxes and bypass logic stay in reg_file_neg.

Test Plan:
1. Reset: drive Rstb=0 mid-cycle after loading R2=0x155 -> RdDataA/B read 0x000 immediately (before any Clkb edge), WrAck=0.
2. Write/read: write R1=0x2AA, then R3=0x0F0 on consecutive falling edges -> RdAddrA=1 returns 0x2AA, RdAddrB=3 returns 0x0F0, WrAck high for exactly one cycle after each write.
3. Bypass: with BYPASS=1, R2=0x001 and a same-cycle write of 0x3FF to R2 with RdAddrA=RdAddrB=2 -> both ports show 0x3FF before the edge. Repeat with BYPASS=0 -> both show 0x001 until the edge, then 0x3FF.
4. Clear priority: all registers non-zero; ClrAll=1 and WrEn=1 writing R0=0x123 on the same edge -> every register reads 0x000, WrAck=0.
5. Zero register: ZERO_REG0=1, write R0=0x3FF -> R0 reads 0x000 before and after the edge, WrAck=0. A write of 0x3FF to R1 in the next cycle completes normally.
6. Parametrisation: WIDTH=16, DEPTH=8, writing 0xBEEF to R7 and 0x1234 to R4 -> RdDataA=0xBEEF (addr 7), RdDataB=0x1234 (addr 4), other words 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor datapath constants.
//   WORD_W     : datapath word width in bits
//   NUM_REGS   : number of general-purpose registers
//   REG_ADDR_W : register index width
//   R0..R3     : named register indices
package proc_pkg;

  localparam int WORD_W     = 10;
  localparam int NUM_REGS   = 4;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  localparam logic [REG_ADDR_W-1:0] R0 = REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] R1 = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] R2 = REG_ADDR_W'(2);
  localparam logic [REG_ADDR_W-1:0] R3 = REG_ADDR_W'(3);

endpackage

// File: rtl/reg_word_neg.sv
// One WIDTH-bit storage word clocked on the falling edge of clkb_i.
//   clkb_i : clock, state changes on the falling edge
//   rstb_i : asynchronous active-low reset, clears the word
//   en_i   : load d_i at the next falling edge
//   clr_i  : synchronous clear, wins over en_i
//   d_i    : load data
//   q_o    : stored word
module reg_word_neg #(
  parameter int WIDTH = 10
) (
  input  logic             clkb_i,
  input  logic             rstb_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (clr_i) begin
      word_d = '0;
    end else if (en_i) begin
      word_d = d_i;
    end
  end

  always_ff @(negedge clkb_i or negedge rstb_i) begin
    if (!rstb_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file_neg.sv
// Register file: DEPTH words of WIDTH bits, one write port, two
// independent combinational read ports, all storage on the falling edge.
//   Clkb    : clock, state changes on the falling edge
//   Rstb    : asynchronous active-low reset (words and WrAck)
//   WrEn    : write enable
//   WrAddr  : write address
//   WrData  : write data
//   ClrAll  : synchronous clear of every word, wins over a write
//   RdAddrA : read port A address
//   RdAddrB : read port B address
//   RdDataA : read port A data
//   RdDataB : read port B data
//   WrAck   : one-cycle pulse after each accepted write
// Options: ZERO_REG0 hardwires R0 to zero; BYPASS forwards WrData to a
// read port addressing the word being written in the same cycle.
module reg_file_neg
  import proc_pkg::*;
#(
  parameter int  WIDTH     = WORD_W,
  parameter int  DEPTH     = NUM_REGS,
  parameter int  ZERO_REG0 = 0,
  parameter int  BYPASS    = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              Clkb,
  input  logic              Rstb,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              ClrAll,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataA,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              WrAck
);

  logic [WIDTH-1:0] words [DEPTH];
  logic             wr_r0_blocked;
  logic             wr_accept;
  logic             wr_ack_q;
  logic             wr_ack_d;

  // A write only counts when it actually lands in storage: a clear in
  // the same cycle drops it, and a hardwired R0 swallows it.
  assign wr_r0_blocked = (ZERO_REG0 != 0) && (WrAddr == '0);
  assign wr_accept     = WrEn && !ClrAll && !wr_r0_blocked;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if ((ZERO_REG0 != 0) && (i == 0)) begin : g_zero
      assign words[i] = '0;
    end else begin : g_reg
      reg_word_neg #(
        .WIDTH (WIDTH)
      ) u_word (
        .clkb_i (Clkb),
        .rstb_i (Rstb),
        .en_i   (WrEn && (WrAddr == ADDR_W'(i))),
        .clr_i  (ClrAll),
        .d_i    (WrData),
        .q_o    (words[i])
      );
    end
  end

  // Read muxes. Bypass is keyed on wr_accept so a dropped write never
  // shows up on a read port; the R0 override comes last so the hardwired
  // zero also covers the bypass path.
  always_comb begin
    RdDataA = words[RdAddrA];
    RdDataB = words[RdAddrB];
    if ((BYPASS != 0) && wr_accept && (WrAddr == RdAddrA)) begin
      RdDataA = WrData;
    end
    if ((BYPASS != 0) && wr_accept && (WrAddr == RdAddrB)) begin
      RdDataB = WrData;
    end
    if ((ZERO_REG0 != 0) && (RdAddrA == '0)) begin
      RdDataA = '0;
    end
    if ((ZERO_REG0 != 0) && (RdAddrB == '0)) begin
      RdDataB = '0;
    end
  end

  assign wr_ack_d = wr_accept;

  always_ff @(negedge Clkb or negedge Rstb) begin
    if (!Rstb) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
    end
  end

  assign WrAck = wr_ack_q;

endmodule

// File: tb/tb_reg_file_neg.sv
module tb_reg_file_neg;
  import proc_pkg::*;

  localparam int W    = WORD_W;
  localparam int D    = NUM_REGS;
  localparam int AW   = REG_ADDR_W;
  localparam int NCFG = 3;

  // ---------------- clock / reset ----------------
  logic clkb = 1'b1;
  always #5 clkb = ~clkb;
  logic rstb;

  // ---------------- 10-bit instances (shared stimulus) ----------------
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          clr_all;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rd_b;
  logic [W-1:0]  rda [NCFG];
  logic [W-1:0]  rdb [NCFG];
  logic          ack [NCFG];

  // config 0: bypass on; config 1: bypass off; config 2: zero R0 + bypass
  bit cfg_zero [NCFG] = '{1'b0, 1'b0, 1'b1};
  bit cfg_byp  [NCFG] = '{1'b1, 1'b0, 1'b1};

  reg_file_neg #(.WIDTH(W), .DEPTH(D), .ZERO_REG0(0), .BYPASS(1)) u_byp (
    .Clkb(clkb), .Rstb(rstb), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .ClrAll(clr_all), .RdAddrA(rd_a), .RdAddrB(rd_b),
    .RdDataA(rda[0]), .RdDataB(rdb[0]), .WrAck(ack[0]));

  reg_file_neg #(.WIDTH(W), .DEPTH(D), .ZERO_REG0(0), .BYPASS(0)) u_nob (
    .Clkb(clkb), .Rstb(rstb), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .ClrAll(clr_all), .RdAddrA(rd_a), .RdAddrB(rd_b),
    .RdDataA(rda[1]), .RdDataB(rdb[1]), .WrAck(ack[1]));

  reg_file_neg #(.WIDTH(W), .DEPTH(D), .ZERO_REG0(1), .BYPASS(1)) u_zr (
    .Clkb(clkb), .Rstb(rstb), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .ClrAll(clr_all), .RdAddrA(rd_a), .RdAddrB(rd_b),
    .RdDataA(rda[2]), .RdDataB(rdb[2]), .WrAck(ack[2]));

  // ---------------- 16x8 instance ----------------
  logic        w16_we;
  logic [2:0]  w16_wa;
  logic [15:0] w16_wd;
  logic        w16_clr;
  logic [2:0]  w16_ra;
  logic [2:0]  w16_rb;
  logic [15:0] w16_rda;
  logic [15:0] w16_rdb;
  logic        w16_ack;

  reg_file_neg #(.WIDTH(16), .DEPTH(8), .ZERO_REG0(0), .BYPASS(1)) u_w16 (
    .Clkb(clkb), .Rstb(rstb), .WrEn(w16_we), .WrAddr(w16_wa), .WrData(w16_wd),
    .ClrAll(w16_clr), .RdAddrA(w16_ra), .RdAddrB(w16_rb),
    .RdDataA(w16_rda), .RdDataB(w16_rdb), .WrAck(w16_ack));

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [NCFG][D];
  bit           m_ack [NCFG];

  function automatic bit model_accepts(int c);
    return wr_en && !clr_all && !(cfg_zero[c] && wr_addr == 0);
  endfunction

  function automatic logic [W-1:0] model_read(int c, logic [AW-1:0] a);
    if (cfg_zero[c] && a == 0) return '0;
    if (cfg_byp[c] && model_accepts(c) && wr_addr == a) return wr_data;
    return m_mem[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_ack[c] = 1'b0;
      for (int a = 0; a < D; a++) m_mem[c][a] = '0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCFG; c++) begin
      m_ack[c] = model_accepts(c);
      if (clr_all) begin
        for (int a = 0; a < D; a++) m_mem[c][a] = '0;
      end else if (model_accepts(c)) begin
        m_mem[c][wr_addr] = wr_data;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reads(string tag);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("%s cfg%0d rdA@%0d", tag, c, rd_a), 32'(rda[c]), 32'(model_read(c, rd_a)));
      chk($sformatf("%s cfg%0d rdB@%0d", tag, c, rd_b), 32'(rdb[c]), 32'(model_read(c, rd_b)));
    end
  endtask

  task automatic check_acks(string tag);
    for (int c = 0; c < NCFG; c++)
      chk($sformatf("%s cfg%0d WrAck", tag, c), 32'(ack[c]), 32'(m_ack[c]));
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic we, logic [AW-1:0] wa, logic [W-1:0] wd, logic clr,
                       logic [AW-1:0] ra, logic [AW-1:0] rb);
    @(posedge clkb);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd; clr_all = clr; rd_a = ra; rd_b = rb;
  endtask

  // Pre-edge check, falling edge, post-edge check against the model.
  task automatic cycle(string tag);
    #1;
    check_reads({tag, " pre"});
    @(negedge clkb);
    model_edge();
    #1;
    check_acks(tag);
    check_reads({tag, " post"});
  endtask

  // ---------------- directed vectors (config 0, from all-zero state) ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          clr;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  pre_a;
    logic [W-1:0]  pre_b;
    logic          ack;
    logic [W-1:0]  post_a;
    logic [W-1:0]  post_b;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, R1, 10'h2AA, 1'b0, R1, R3, 10'h2AA, 10'h000, 1'b1, 10'h2AA, 10'h000};
    tbl[1] = '{1'b1, R3, 10'h0F0, 1'b0, R1, R3, 10'h2AA, 10'h0F0, 1'b1, 10'h2AA, 10'h0F0};
    tbl[2] = '{1'b0, R0, 10'h000, 1'b0, R1, R3, 10'h2AA, 10'h0F0, 1'b0, 10'h2AA, 10'h0F0};
    tbl[3] = '{1'b1, R2, 10'h001, 1'b0, R2, R2, 10'h001, 10'h001, 1'b1, 10'h001, 10'h001};
    tbl[4] = '{1'b1, R2, 10'h3FF, 1'b0, R2, R2, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 10'h3FF};
    tbl[5] = '{1'b1, R0, 10'h155, 1'b0, R0, R2, 10'h155, 10'h3FF, 1'b1, 10'h155, 10'h3FF};
    tbl[6] = '{1'b1, R0, 10'h123, 1'b1, R0, R1, 10'h155, 10'h2AA, 1'b0, 10'h000, 10'h000};
    tbl[7] = '{1'b0, R0, 10'h000, 1'b0, R2, R3, 10'h000, 10'h000, 1'b0, 10'h000, 10'h000};
    tbl[8] = '{1'b1, R1, 10'h0AA, 1'b0, R1, R1, 10'h0AA, 10'h0AA, 1'b1, 10'h0AA, 10'h0AA};
    tbl[9] = '{1'b1, R1, 10'h155, 1'b0, R1, R0, 10'h155, 10'h000, 1'b1, 10'h155, 10'h000};

    // reset state
    rstb = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_all = 1'b0; rd_a = R1; rd_b = R2;
    w16_we = 1'b0; w16_wa = '0; w16_wd = '0; w16_clr = 1'b0; w16_ra = 3'd7; w16_rb = 3'd4;
    model_reset();
    #2;
    check_reads("reset");
    check_acks("reset");
    chk("reset w16 rdA", 32'(w16_rda), 32'h0);
    chk("reset w16 ack", 32'(w16_ack), 32'h0);
    #1;
    rstb = 1'b1;

    // 16-bit x 8 instance
    @(posedge clkb); #1;
    w16_we = 1'b1; w16_wa = 3'd7; w16_wd = 16'hBEEF;
    @(negedge clkb); #1;
    chk("w16 ack R7", 32'(w16_ack), 32'h1);
    @(posedge clkb); #1;
    w16_wa = 3'd4; w16_wd = 16'h1234;
    @(negedge clkb); #1;
    chk("w16 ack R4", 32'(w16_ack), 32'h1);
    @(posedge clkb); #1;
    w16_we = 1'b0; w16_ra = 3'd7; w16_rb = 3'd4;
    #1;
    chk("w16 rdA@7", 32'(w16_rda), 32'hBEEF);
    chk("w16 rdB@4", 32'(w16_rdb), 32'h1234);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp16;
      exp16 = (i == 7) ? 16'hBEEF : (i == 4) ? 16'h1234 : 16'h0000;
      w16_ra = 3'(i); w16_rb = 3'(7 - i);
      #1;
      chk($sformatf("w16 scan rdA@%0d", i), 32'(w16_rda), 32'(exp16));
    end
    @(negedge clkb); #1;
    chk("w16 ack idle", 32'(w16_ack), 32'h0);

    // directed table
    for (int v = 0; v < 10; v++) begin
      drive(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].clr, tbl[v].ra, tbl[v].rb);
      #1;
      chk($sformatf("vec%0d pre rdA", v), 32'(rda[0]), 32'(tbl[v].pre_a));
      chk($sformatf("vec%0d pre rdB", v), 32'(rdb[0]), 32'(tbl[v].pre_b));
      check_reads($sformatf("vec%0d pre", v));
      @(negedge clkb);
      model_edge();
      #1;
      chk($sformatf("vec%0d WrAck", v), 32'(ack[0]), 32'(tbl[v].ack));
      chk($sformatf("vec%0d post rdA", v), 32'(rda[0]), 32'(tbl[v].post_a));
      chk($sformatf("vec%0d post rdB", v), 32'(rdb[0]), 32'(tbl[v].post_b));
      check_acks($sformatf("vec%0d", v));
      check_reads($sformatf("vec%0d post", v));
    end

    // mid-cycle asynchronous reset right after a write to R2
    drive(1'b1, R2, 10'h155, 1'b0, R2, R2);
    cycle("load R2");
    @(posedge clkb); #1;
    wr_en = 1'b0;
    #1;
    chk("pre-reset rdA R2", 32'(rda[0]), 32'h155);
    chk("pre-reset WrAck", 32'(ack[0]), 32'h1);
    rstb = 1'b0;
    model_reset();
    #1;
    check_reads("async reset");
    check_acks("async reset");
    rstb = 1'b1;
    @(negedge clkb); #1;
    check_reads("after release");
    check_acks("after release");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
            W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 15) == 0),
            AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
      cycle($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
